// File: rtl/mem_bus_responder_if.sv
// Memory bus bundle between the CPU controller (master) and the memory responder (slave).
interface mem_bus_responder_if;
    logic        MREQ_N;
    logic        R_W_N;
    logic        MIRQ_N;
    logic [15:0] ADDR;
    logic [15:0] WDATA;
    logic [15:0] m_bus;
    logic        MRDY;
    logic        MBUSY;
    logic        MERR;

    modport master (
        output MREQ_N, R_W_N, MIRQ_N, ADDR, WDATA,
        input  m_bus, MRDY, MBUSY, MERR
    );

    modport slave (
        input  MREQ_N, R_W_N, MIRQ_N, ADDR, WDATA,
        output m_bus, MRDY, MBUSY, MERR
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Word-addressed RAM responder with programmable wait states and a four-phase MREQ_N/MRDY handshake.
// Optional out-of-range bus error reporting is enabled by defining MEM_BUSERR_EN.
module mem_bus_responder #(
    parameter int AW       = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic                 CLK,
    input  logic                 CLR,
    mem_bus_responder_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RELEASE} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   m_bus_q, m_bus_d;
    logic          rd_q, rd_d;
    logic          oor_q, oor_d;
    logic          mrdy_q, mrdy_d;
    logic          mbusy_q, mbusy_d;
    logic          merr_q, merr_d;
    logic          we;
    logic          oor_in;

    logic [15:0]   mem [0:(1<<AW)-1];

`ifdef MEM_BUSERR_EN
    assign oor_in = (bus.ADDR >> AW) != 16'd0;
`else
    // Upper address bits alias onto the decoded range.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.ADDR[15:AW];
    assign oor_in         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        oor_d   = oor_q;
        m_bus_d = m_bus_q;
        mrdy_d  = 1'b0;
        merr_d  = 1'b0;
        mbusy_d = mbusy_q;
        we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.MREQ_N) begin
                    addr_d  = bus.ADDR[AW-1:0];
                    wdata_d = bus.WDATA;
                    rd_d    = bus.R_W_N | ~bus.MIRQ_N;
                    oor_d   = oor_in;
                    mbusy_d = 1'b1;
                    cnt_d   = 4'(WAIT_CYC);
                    state_d = (WAIT_CYC == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                // A request withdrawn while waiting is dropped without touching RAM.
                if (bus.MREQ_N) begin
                    mbusy_d = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mrdy_d  = 1'b1;
                merr_d  = oor_q;
                state_d = S_RELEASE;
                if (rd_q) m_bus_d = oor_q ? 16'h0000 : mem[addr_q];
                else      we      = ~oor_q;
            end
            S_RELEASE: begin
                if (bus.MREQ_N) begin
                    mbusy_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            m_bus_q <= 16'h0000;
            mrdy_q  <= 1'b0;
            mbusy_q <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_bus_q <= m_bus_d;
            mrdy_q  <= mrdy_d;
            mbusy_q <= mbusy_d;
            merr_q  <= merr_d;
        end
    end

    // Latched request fields only matter once accepted, so they need no reset.
    always_ff @(posedge CLK) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rd_q    <= rd_d;
        oor_q   <= oor_d;
    end

    always_ff @(posedge CLK) begin
        if (we && !CLR) mem[addr_q] <= wdata_q;
    end

    assign bus.m_bus = m_bus_q;
    assign bus.MRDY  = mrdy_q;
    assign bus.MBUSY = mbusy_q;
    assign bus.MERR  = merr_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances (0, 1 and 3 wait states) driven by directed requests.
module tb_mem_bus_responder;

    localparam int AW = 8;
    localparam int WC [3] = '{0, 1, 3};

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    logic        mreq_n  [3];
    logic        rw_r    [3];
    logic        mirq_r  [3];
    logic [15:0] addr_r  [3];
    logic [15:0] wdata_r [3];
    logic [15:0] mbus_w  [3];
    logic        mrdy_w  [3];
    logic        mbusy_w [3];
    logic        merr_w  [3];

    mem_bus_responder_if bus0 ();
    mem_bus_responder_if bus1 ();
    mem_bus_responder_if bus2 ();

    assign bus0.MREQ_N = mreq_n[0];  assign bus1.MREQ_N = mreq_n[1];  assign bus2.MREQ_N = mreq_n[2];
    assign bus0.R_W_N  = rw_r[0];    assign bus1.R_W_N  = rw_r[1];    assign bus2.R_W_N  = rw_r[2];
    assign bus0.MIRQ_N = mirq_r[0];  assign bus1.MIRQ_N = mirq_r[1];  assign bus2.MIRQ_N = mirq_r[2];
    assign bus0.ADDR   = addr_r[0];  assign bus1.ADDR   = addr_r[1];  assign bus2.ADDR   = addr_r[2];
    assign bus0.WDATA  = wdata_r[0]; assign bus1.WDATA  = wdata_r[1]; assign bus2.WDATA  = wdata_r[2];
    assign mbus_w[0]  = bus0.m_bus;  assign mbus_w[1]  = bus1.m_bus;  assign mbus_w[2]  = bus2.m_bus;
    assign mrdy_w[0]  = bus0.MRDY;   assign mrdy_w[1]  = bus1.MRDY;   assign mrdy_w[2]  = bus2.MRDY;
    assign mbusy_w[0] = bus0.MBUSY;  assign mbusy_w[1] = bus1.MBUSY;  assign mbusy_w[2] = bus2.MBUSY;
    assign merr_w[0]  = bus0.MERR;   assign merr_w[1]  = bus1.MERR;   assign merr_w[2]  = bus2.MERR;

    mem_bus_responder #(.AW(AW), .WAIT_CYC(0)) u_w0 (.CLK(clk), .CLR(clr), .bus(bus0.slave));
    mem_bus_responder #(.AW(AW), .WAIT_CYC(1)) u_w1 (.CLK(clk), .CLR(clr), .bus(bus1.slave));
    mem_bus_responder #(.AW(AW), .WAIT_CYC(3)) u_w2 (.CLK(clk), .CLR(clr), .bus(bus2.slave));

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    // Transaction-age model: n counts edges since the request was accepted.
    // Edges 1..W are wait edges (abortable), edge W+1 performs the access,
    // later edges wait for the request to be withdrawn.
    bit          m_busy  [3];
    int          m_n     [3];
    logic [15:0] m_addr  [3];
    logic [15:0] m_wdata [3];
    bit          m_rd    [3];
    logic [15:0] m_bus   [3];
    bit          m_mrdy  [3];
    bit          m_merr  [3];
    logic [15:0] mmem    [3][256];

    function automatic bit out_of_range(input logic [15:0] a);
`ifdef MEM_BUSERR_EN
        return a[15:8] != 8'h00;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            m_mrdy[d] = 1'b0;
            m_merr[d] = 1'b0;
            if (clr) begin
                m_busy[d] = 1'b0;
                m_bus[d]  = 16'h0000;
            end else if (!m_busy[d]) begin
                if (!mreq_n[d]) begin
                    m_busy[d]  = 1'b1;
                    m_n[d]     = 0;
                    m_addr[d]  = addr_r[d];
                    m_wdata[d] = wdata_r[d];
                    m_rd[d]    = rw_r[d] | ~mirq_r[d];
                end
            end else begin
                m_n[d]++;
                if (m_n[d] <= WC[d]) begin
                    if (mreq_n[d]) m_busy[d] = 1'b0;
                end else if (m_n[d] == WC[d] + 1) begin
                    m_mrdy[d] = 1'b1;
                    m_merr[d] = out_of_range(m_addr[d]);
                    if (m_rd[d])
                        m_bus[d] = m_merr[d] ? 16'h0000 : mmem[d][m_addr[d][7:0]];
                    else if (!m_merr[d])
                        mmem[d][m_addr[d][7:0]] = m_wdata[d];
                end else if (mreq_n[d]) begin
                    m_busy[d] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("d%0d_mrdy", d),  32'(mrdy_w[d]),  32'(m_mrdy[d]));
                chk($sformatf("d%0d_mbusy", d), 32'(mbusy_w[d]), 32'(m_busy[d]));
                chk($sformatf("d%0d_merr", d),  32'(merr_w[d]),  32'(m_merr[d]));
                chk($sformatf("d%0d_m_bus", d), 32'(mbus_w[d]),  32'(m_bus[d]));
            end
        end
    end

    // One complete handshake; addr/data/type are scrambled right after acceptance.
    task automatic do_req(input int d, input logic [15:0] a, input logic [15:0] wd,
                          input logic rw, input logic mirq, input int hold,
                          output int lat, output logic [15:0] rdata, output logic merr,
                          output int extra, output logic busy_pre, output logic busy_post);
        @(posedge clk); #2;
        addr_r[d] = a; wdata_r[d] = wd; rw_r[d] = rw; mirq_r[d] = mirq; mreq_n[d] = 1'b0;
        lat = -1; rdata = 16'h0000; merr = 1'b0; extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                addr_r[d] = ~a; wdata_r[d] = 16'hDEAD; rw_r[d] = ~rw; mirq_r[d] = ~mirq;
            end
            if (mrdy_w[d]) begin
                lat = c; rdata = mbus_w[d]; merr = merr_w[d];
                break;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (mrdy_w[d]) extra++;
        end
        busy_pre = mbusy_w[d];
        #1 mreq_n[d] = 1'b1;
        @(posedge clk); #1;
        busy_post = mbusy_w[d];
    endtask

    int          lat, extra, rdy_cnt;
    logic [15:0] rdata;
    logic        merr, bpre, bpost;

    initial begin
        for (int d = 0; d < 3; d++) begin
            mreq_n[d] = 1'b1; rw_r[d] = 1'b1; mirq_r[d] = 1'b1;
            addr_r[d] = 16'h0000; wdata_r[d] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #2 clr = 1'b0;
        chk_en = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_m_bus%0d", d), 32'(mbus_w[d]),  32'h0);
            chk($sformatf("rst_mrdy%0d", d),  32'(mrdy_w[d]),  32'h0);
            chk($sformatf("rst_mbusy%0d", d), 32'(mbusy_w[d]), 32'h0);
            chk($sformatf("rst_merr%0d", d),  32'(merr_w[d]),  32'h0);
        end

        // 1: one wait state, write then read back
        do_req(1, 16'h0010, 16'hA5A5, 1'b0, 1'b1, 0, lat, rdata, merr, extra, bpre, bpost);
        chk("t1_wr_lat", 32'(lat), 32'd2);
        do_req(1, 16'h0010, 16'h0000, 1'b1, 1'b1, 0, lat, rdata, merr, extra, bpre, bpost);
        chk("t1_rd_lat", 32'(lat), 32'd2);
        chk("t1_rdata", 32'(rdata), 32'h0000A5A5);

        // 2: zero wait states, fetch with R_W_N=0 must read, not write
        do_req(0, 16'h0010, 16'hA5A5, 1'b0, 1'b1, 0, lat, rdata, merr, extra, bpre, bpost);
        chk("t2_wr_lat", 32'(lat), 32'd1);
        do_req(0, 16'h0010, 16'hFFFF, 1'b0, 1'b0, 0, lat, rdata, merr, extra, bpre, bpost);
        chk("t2_fetch_lat", 32'(lat), 32'd1);
        chk("t2_fetch_data", 32'(rdata), 32'h0000A5A5);
        do_req(0, 16'h0010, 16'h0000, 1'b1, 1'b1, 0, lat, rdata, merr, extra, bpre, bpost);
        chk("t2_ram_kept", 32'(rdata), 32'h0000A5A5);

        // 3: request held 5 cycles past MRDY
        do_req(1, 16'h0010, 16'h0000, 1'b1, 1'b1, 5, lat, rdata, merr, extra, bpre, bpost);
        chk("t3_lat", 32'(lat), 32'd2);
        chk("t3_extra_mrdy", 32'(extra), 32'd0);
        chk("t3_busy_held", 32'(bpre), 32'd1);
        chk("t3_busy_drop", 32'(bpost), 32'd0);

        // 4: three wait states, write aborted mid-wait
        do_req(2, 16'h0020, 16'h5555, 1'b0, 1'b1, 0, lat, rdata, merr, extra, bpre, bpost);
        chk("t4_wr_lat", 32'(lat), 32'd4);
        @(posedge clk); #2;
        addr_r[2] = 16'h0020; wdata_r[2] = 16'h1234; rw_r[2] = 1'b0; mirq_r[2] = 1'b1; mreq_n[2] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 mreq_n[2] = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (mrdy_w[2]) rdy_cnt++;
            if (i == 0) chk("t4_busy_abort", 32'(mbusy_w[2]), 32'd0);
        end
        chk("t4_no_mrdy", 32'(rdy_cnt), 32'd0);
        do_req(2, 16'h0020, 16'h0000, 1'b1, 1'b1, 0, lat, rdata, merr, extra, bpre, bpost);
        chk("t4_unchanged", 32'(rdata), 32'h00005555);

        // 5: reset while waiting discards the pending write
        @(posedge clk); #2;
        addr_r[2] = 16'h0020; wdata_r[2] = 16'h7777; rw_r[2] = 1'b0; mirq_r[2] = 1'b1; mreq_n[2] = 1'b0;
        @(posedge clk); #2;
        clr = 1'b1; mreq_n[2] = 1'b1;
        @(posedge clk); #1;
        chk("t5_m_bus", 32'(mbus_w[2]), 32'h0);
        chk("t5_mrdy", 32'(mrdy_w[2]), 32'h0);
        chk("t5_mbusy", 32'(mbusy_w[2]), 32'h0);
        chk("t5_merr", 32'(merr_w[2]), 32'h0);
        #1 clr = 1'b0;
        do_req(2, 16'h0020, 16'h0000, 1'b1, 1'b1, 0, lat, rdata, merr, extra, bpre, bpost);
        chk("t5_lat", 32'(lat), 32'd4);
        chk("t5_no_write", 32'(rdata), 32'h00005555);

        // 6: addresses above the decoded range
        do_req(1, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 0, lat, rdata, merr, extra, bpre, bpost);
        do_req(1, 16'h0100, 16'h0000, 1'b1, 1'b1, 0, lat, rdata, merr, extra, bpre, bpost);
`ifdef MEM_BUSERR_EN
        chk("t6_oor_rdata", 32'(rdata), 32'h0000);
        chk("t6_oor_merr", 32'(merr), 32'd1);
`else
        chk("t6_alias_rdata", 32'(rdata), 32'h0000BEEF);
        chk("t6_alias_merr", 32'(merr), 32'd0);
`endif
        do_req(1, 16'h0100, 16'h2222, 1'b0, 1'b1, 0, lat, rdata, merr, extra, bpre, bpost);
        do_req(1, 16'h0000, 16'h0000, 1'b1, 1'b1, 0, lat, rdata, merr, extra, bpre, bpost);
`ifdef MEM_BUSERR_EN
        chk("t6_wr_suppressed", 32'(rdata), 32'h0000BEEF);
`else
        chk("t6_wr_aliased", 32'(rdata), 32'h00002222);
`endif
        chk("t6_lat", 32'(lat), 32'd2);

        repeat (3) @(posedge clk);
        #1 chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
